// File: rtl/cu_sleep_req_gen_if.sv
// Memory handshake and data-cache flush handshake seen by the per-CU sleep request generator.
interface cu_sleep_req_gen_if;
  logic mem_req_valid;
  logic mem_req_ready;
  logic mem_rsp_valid;
  logic req_stall;
  logic dcache_flush_req;
  logic dcache_flush_done;

  modport master (
    output mem_req_valid, mem_req_ready, mem_rsp_valid, dcache_flush_done,
    input  req_stall, dcache_flush_req
  );

  modport slave (
    input  mem_req_valid, mem_req_ready, mem_rsp_valid, dcache_flush_done,
    output req_stall, dcache_flush_req
  );
endinterface

// File: rtl/cu_sleep_req_gen.sv
// Per-CU sleep handshake initiator: idle filter, cache flush, memory drain, sleep request pulse.
// Optional drain latency counter enabled by defining CU_SLEEP_DRAIN_PERF_EN.
module cu_sleep_req_gen #(
  parameter int unsigned NUM_WARPS       = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned IDLE_CYCLES     = 4,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_WARPS-1:0] warp_active_i,
  cu_sleep_req_gen_if.slave    bus,
  output logic                 sleep_req_o,
  output logic                 delay_sleep_o,
  output logic [CW-1:0]        outstanding_o,
  output logic                 err_o,
  output logic [31:0]          drain_cycles_o
);

  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] OUT_MAX   = CW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    RUN, IDLE_WAIT, FLUSH, DRAIN, REQ, SLEEP
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic          err_q, err_d;
  logic          idle, inc, dec, seq_active;

  assign idle       = (warp_active_i == '0);
  assign inc        = bus.mem_req_valid & bus.mem_req_ready & (out_q != OUT_MAX);
  assign dec        = bus.mem_rsp_valid;
  assign seq_active = (state_q == FLUSH) || (state_q == DRAIN) ||
                      (state_q == REQ)   || (state_q == SLEEP);

  // Next-state, outstanding tracking and sticky error
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    out_d      = out_q;
    err_d      = err_q;

    unique case ({inc, dec})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   if (out_q != '0) out_d = out_q - CW'(1);
               else             err_d = 1'b1;
      default: out_d = out_q;
    endcase

    if (bus.dcache_flush_done && (state_q != FLUSH)) err_d = 1'b1;
    if (!idle && seq_active)                          err_d = 1'b1;

    unique case (state_q)
      RUN: begin
        if (idle) begin
          state_d    = IDLE_WAIT;
          idle_cnt_d = IW'(1);
        end
      end
      IDLE_WAIT: begin
        if (!idle) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= IDLE_LAST) begin
          state_d    = FLUSH;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      FLUSH:   if (bus.dcache_flush_done) state_d = DRAIN;
      DRAIN:   if ((out_q == '0) && !inc) state_d = REQ;
      REQ:     state_d = SLEEP;
      SLEEP:   state_d = SLEEP;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      idle_cnt_q <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  // All outputs decode registered state only
  assign bus.req_stall        = (out_q == OUT_MAX);
  assign bus.dcache_flush_req = (state_q == FLUSH);
  assign sleep_req_o          = (state_q == REQ);
  assign delay_sleep_o        = (state_q == FLUSH) || (state_q == DRAIN) || (out_q != '0);
  assign outstanding_o        = out_q;
  assign err_o                = err_q;

`ifdef CU_SLEEP_DRAIN_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Counts FLUSH+DRAIN cycles; frozen once REQ is reached since it no longer increments
  always_comb begin
    perf_d = perf_q;
    if ((state_q == IDLE_WAIT) && (state_d == FLUSH)) begin
      perf_d = '0;
    end else if (((state_q == FLUSH) || (state_q == DRAIN)) && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign drain_cycles_o = perf_q;
`else
  assign drain_cycles_o = '0;
`endif

endmodule

// File: tb/tb_cu_sleep_req_gen.sv
// Directed self-checking bench for cu_sleep_req_gen (default parameters).
module tb_cu_sleep_req_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  warps;
  logic        sleep_req, delay_sleep, err;
  logic [3:0]  outstanding;
  logic [31:0] drain_cycles;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_drain;

  cu_sleep_req_gen_if bus ();

  cu_sleep_req_gen dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .warp_active_i  (warps),
    .bus            (bus),
    .sleep_req_o    (sleep_req),
    .delay_sleep_o  (delay_sleep),
    .outstanding_o  (outstanding),
    .err_o          (err),
    .drain_cycles_o (drain_cycles)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n                 = 1'b0;
    warps                 = 4'b0001;
    bus.mem_req_valid     = 1'b0;
    bus.mem_req_ready     = 1'b0;
    bus.mem_rsp_valid     = 1'b0;
    bus.dcache_flush_done = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n                 = 1'b0;
    warps                 = 4'b0001;
    bus.mem_req_valid     = 1'b0;
    bus.mem_req_ready     = 1'b0;
    bus.mem_rsp_valid     = 1'b0;
    bus.dcache_flush_done = 1'b0;
    #3;
    n_cmp++;
    if ({sleep_req, delay_sleep, bus.req_stall, bus.dcache_flush_req, err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b required 00000",
                        {sleep_req, delay_sleep, bus.req_stall, bus.dcache_flush_req, err});
    end
    n_cmp++;
    if (outstanding !== 4'd0) begin
      n_bad++; $display("FAIL reset_outstanding: got %0d required 0", outstanding);
    end
    n_cmp++;
    if (drain_cycles !== 32'd0) begin
      n_bad++; $display("FAIL reset_drain_cycles: got %0d required 0", drain_cycles);
    end
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic();
    do_reset();
    step(10);
    n_cmp++;
    if (bus.dcache_flush_req !== 1'b0) begin
      n_bad++; $display("FAIL basic_busy_noflush: got %b required 0", bus.dcache_flush_req);
    end
    warps = 4'b0000;
    step(3);
    n_cmp++;
    if (bus.dcache_flush_req !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle3_noflush: got %b required 0", bus.dcache_flush_req);
    end
    step(1);
    n_cmp++;
    if ({bus.dcache_flush_req, delay_sleep} !== 2'b11) begin
      n_bad++; $display("FAIL basic_flush_entry: got %b required 11", {bus.dcache_flush_req, delay_sleep});
    end
    step(2);
    bus.dcache_flush_done = 1'b1;
    step(1);
    bus.dcache_flush_done = 1'b0;
    n_cmp++;
    if ({bus.dcache_flush_req, delay_sleep, sleep_req} !== 3'b010) begin
      n_bad++; $display("FAIL basic_drain: got %b required 010", {bus.dcache_flush_req, delay_sleep, sleep_req});
    end
    step(1);
    n_cmp++;
    if ({sleep_req, delay_sleep} !== 2'b10) begin
      n_bad++; $display("FAIL basic_req_pulse: got %b required 10", {sleep_req, delay_sleep});
    end
    n_cmp++;
    if (drain_cycles !== exp_drain) begin
      n_bad++; $display("FAIL basic_drain_cycles: got %0d required %0d", drain_cycles, exp_drain);
    end
    step(1);
    n_cmp++;
    if ({sleep_req, delay_sleep, err} !== 3'b000) begin
      n_bad++; $display("FAIL basic_sleep: got %b required 000", {sleep_req, delay_sleep, err});
    end
    step(3);
    n_cmp++;
    if ((sleep_req !== 1'b0) || (drain_cycles !== exp_drain)) begin
      n_bad++; $display("FAIL basic_sleep_hold: got sleep_req=%b drain=%0d required 0/%0d",
                        sleep_req, drain_cycles, exp_drain);
    end
    warps = 4'b0001;
    step(1);
    n_cmp++;
    if ({err, sleep_req} !== 2'b10) begin
      n_bad++; $display("FAIL basic_warp_in_sleep: got %b required 10", {err, sleep_req});
    end
  endtask

  task automatic test_idle_glitch();
    do_reset();
    warps = 4'b0000;
    step(2);
    warps = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step(1);
      n_cmp++;
      if (bus.dcache_flush_req !== 1'b0) begin
        n_bad++; $display("FAIL glitch_noflush[%0d]: got %b required 0", i, bus.dcache_flush_req);
      end
    end
    warps = 4'b0000;
    step(3);
    n_cmp++;
    if (bus.dcache_flush_req !== 1'b0) begin
      n_bad++; $display("FAIL glitch_restart: got %b required 0", bus.dcache_flush_req);
    end
    step(1);
    n_cmp++;
    if ((bus.dcache_flush_req !== 1'b1) || (err !== 1'b0)) begin
      n_bad++; $display("FAIL glitch_flush_after_4: got flush=%b err=%b required 1/0",
                        bus.dcache_flush_req, err);
    end
  endtask

  task automatic test_drain();
    do_reset();
    bus.mem_req_valid = 1'b1;
    bus.mem_req_ready = 1'b1;
    step(3);
    bus.mem_req_valid = 1'b0;
    n_cmp++;
    if ((outstanding !== 4'd3) || (delay_sleep !== 1'b1)) begin
      n_bad++; $display("FAIL drain_issue: got out=%0d delay=%b required 3/1", outstanding, delay_sleep);
    end
    warps = 4'b0000;
    step(4);
    step(2);
    bus.dcache_flush_done = 1'b1;
    step(1);
    bus.dcache_flush_done = 1'b0;
    step(4);
    bus.mem_rsp_valid = 1'b1;
    step(1);
    n_cmp++;
    if (outstanding !== 4'd2) begin
      n_bad++; $display("FAIL drain_rsp1: got %0d required 2", outstanding);
    end
    step(1);
    bus.mem_rsp_valid = 1'b0;
    n_cmp++;
    if (outstanding !== 4'd1) begin
      n_bad++; $display("FAIL drain_rsp2: got %0d required 1", outstanding);
    end
    for (int i = 7; i <= 19; i++) begin
      step(1);
      n_cmp++;
      if ({delay_sleep, sleep_req} !== 2'b10) begin
        n_bad++; $display("FAIL drain_hold[%0d]: got %b required 10", i, {delay_sleep, sleep_req});
      end
    end
    bus.mem_rsp_valid = 1'b1;
    step(1);
    bus.mem_rsp_valid = 1'b0;
    n_cmp++;
    if ({outstanding, delay_sleep, sleep_req} !== {4'd0, 2'b10}) begin
      n_bad++; $display("FAIL drain_last_rsp: got out=%0d delay=%b sleep=%b required 0/1/0",
                        outstanding, delay_sleep, sleep_req);
    end
    step(1);
    n_cmp++;
    if ({sleep_req, delay_sleep, err} !== 3'b100) begin
      n_bad++; $display("FAIL drain_req_pulse: got %b required 100", {sleep_req, delay_sleep, err});
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.mem_req_valid = 1'b1;
    bus.mem_req_ready = 1'b1;
    step(8);
    n_cmp++;
    if ((outstanding !== 4'd8) || (bus.req_stall !== 1'b1)) begin
      n_bad++; $display("FAIL full_count8: got out=%0d stall=%b required 8/1", outstanding, bus.req_stall);
    end
    step(1);
    n_cmp++;
    if (outstanding !== 4'd8) begin
      n_bad++; $display("FAIL full_no_overflow: got %0d required 8", outstanding);
    end
    bus.mem_rsp_valid = 1'b1;
    step(1);
    n_cmp++;
    if ((outstanding !== 4'd7) || (bus.req_stall !== 1'b0)) begin
      n_bad++; $display("FAIL full_simul_stalled: got out=%0d stall=%b required 7/0", outstanding, bus.req_stall);
    end
    step(1);
    n_cmp++;
    if (outstanding !== 4'd7) begin
      n_bad++; $display("FAIL full_simul_keep: got %0d required 7", outstanding);
    end
    bus.mem_req_valid = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    n_cmp++;
    if ((err !== 1'b0) || (delay_sleep !== 1'b1)) begin
      n_bad++; $display("FAIL full_flags: got err=%b delay=%b required 0/1", err, delay_sleep);
    end
  endtask

  task automatic test_errors();
    do_reset();
    bus.mem_rsp_valid = 1'b1;
    step(1);
    bus.mem_rsp_valid = 1'b0;
    n_cmp++;
    if ((err !== 1'b1) || (outstanding !== 4'd0)) begin
      n_bad++; $display("FAIL err_rsp_at_zero: got err=%b out=%0d required 1/0", err, outstanding);
    end
    step(3);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky: got %b required 1", err);
    end
    do_reset();
    bus.dcache_flush_done = 1'b1;
    step(1);
    bus.dcache_flush_done = 1'b0;
    n_cmp++;
    if ({err, bus.dcache_flush_req, delay_sleep} !== 3'b100) begin
      n_bad++; $display("FAIL err_done_in_run: got %b required 100", {err, bus.dcache_flush_req, delay_sleep});
    end
    warps = 4'b0000;
    step(4);
    n_cmp++;
    if ((bus.dcache_flush_req !== 1'b1) || (err !== 1'b1)) begin
      n_bad++; $display("FAIL err_still_sequences: got flush=%b err=%b required 1/1", bus.dcache_flush_req, err);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    bus.mem_req_valid = 1'b1;
    bus.mem_req_ready = 1'b1;
    step(2);
    bus.mem_req_valid = 1'b0;
    warps = 4'b0000;
    step(4);
    bus.dcache_flush_done = 1'b1;
    step(1);
    bus.dcache_flush_done = 1'b0;
    warps = 4'b1000;
    step(1);
    warps = 4'b0000;
    n_cmp++;
    if ({err, delay_sleep, outstanding} !== {2'b11, 4'd2}) begin
      n_bad++; $display("FAIL mid_drain_pre: got err=%b delay=%b out=%0d required 1/1/2",
                        err, delay_sleep, outstanding);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sleep_req, delay_sleep, bus.req_stall, bus.dcache_flush_req, err, outstanding} !== 9'b0) begin
      n_bad++; $display("FAIL mid_drain_async_reset: got %b required 000000000",
                        {sleep_req, delay_sleep, bus.req_stall, bus.dcache_flush_req, err, outstanding});
    end
    n_cmp++;
    if (drain_cycles !== 32'd0) begin
      n_bad++; $display("FAIL mid_drain_perf_reset: got %0d required 0", drain_cycles);
    end
    step(1);
    rst_n = 1'b1;
    warps = 4'b0001;
    step(2);
    n_cmp++;
    if ({sleep_req, delay_sleep, err} !== 3'b000) begin
      n_bad++; $display("FAIL mid_drain_after_release: got %b required 000", {sleep_req, delay_sleep, err});
    end
  endtask

  initial begin
`ifdef CU_SLEEP_DRAIN_PERF_EN
    exp_drain = 32'd4;
`else
    exp_drain = 32'd0;
`endif
    test_reset();
    test_basic();
    test_idle_glitch();
    test_drain();
    test_full();
    test_errors();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
